edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//   Sequences and shares a bank of NUM_CH edge detectors. It drives their
//   synchronous clear, blanks spurious edges while they re-arm, and latches
//   each edge pulse as a pending event. It then grants pending events
//   round-robin to one downstream consumer over a valid/ready handshake.
//   Sits between the per-channel edge detectors and the event/interrupt logic.
// PARAMETERS
//   NUM_CH   4  number of edge-detector channels (2..16)
//   CH_W     2  width of channel index; must equal clog2(NUM_CH)
//   ARM_DLY  2  cycles after clear during which edge_in is ignored (1..15)
// PORTS
//   clk        in   1       clock, all logic on posedge
//   rst        in   1       asynchronous reset, active-high
//   init_n     in   1       synchronous re-initialise, active-low
//   ch_en      in   NUM_CH  per-channel enable; edges on disabled channels ignored
//   edge_in    in   NUM_CH  edge pulses from detectors (one cycle per edge)
//   det_init_n out  1       synchronous clear driven to all detectors, active-low
//   evt_valid  out  1       event available
//   evt_ch     out  CH_W    channel index of presented event
//   evt_ready  in   1       consumer accepts event when evt_valid & evt_ready
//   ovf        out  NUM_CH  sticky: event lost on that channel
//   busy       out  1       state!=RUN | (|pending) | evt_valid
// BEHAVIOUR
//   Reset (rst=1): state=CLR, arm_cnt=0, pending=0, ptr=0, evt_valid=0,
//     evt_ch=0, ovf=0, det_init_n=0, busy=1. All outputs are registered.
//   FSM:
//     CLR: det_init_n=0, edge_in ignored. Exits to ARM on the first clock
//       with init_n=1. Holds while init_n=0.
//     ARM: det_init_n=1, edge_in ignored, arm_cnt counts 0..ARM_DLY-1,
//       then RUN.
//     RUN: edge capture enabled.
//     From any state, init_n=0 forces CLR on the next edge. It clears
//       pending, evt_valid, ovf, arm_cnt. ptr and evt_ch are kept.
//   Capture (RUN only):
//     - edge_in[i] & ch_en[i] sets pending[i].
//     - If pending[i] is already set and not being loaded this cycle,
//       set ovf[i] and keep one event.
//     - If pending[i] is loaded to the output in the same cycle a new
//       edge_in[i] arrives, pending[i] stays 1 and ovf is not set.
//   Output load:
//     - Load condition: !evt_valid | evt_ready.
//     - Select the first pending bit scanning ptr, ptr+1, .. mod NUM_CH.
//     - Register it into evt_ch and set evt_valid=1. Clear that pending
//       bit and set ptr to (selected+1) mod NUM_CH.
//     - If no bit is pending on a load cycle, evt_valid goes to 0.
//   Handshake:
//     - evt_ch is stable while evt_valid & !evt_ready.
//     - evt_valid never drops without acceptance, except on init_n=0 or rst.
//   Latency: edge_in high at clock k sets pending after k. With the output
//     register free, evt_valid=1 after k+1 (2 cycles). Throughput is
//     1 event/cycle when evt_ready is held at 1.
//   Disabled channel: ch_en=0 blocks new captures only. An already-pending
//     event is still delivered.
//   Async rst mid-transfer: outputs return to reset values immediately.
// TESTING
//   1 Reset release, ARM_DLY=2, edge_in=4'hF held:
//     -> det_init_n=0 for 1 cycle, then 2 ARM cycles with no capture.
//     -> RUN reached 3 cycles after rst falls; captures start then.
//   2 RUN, ready=1, edge_in[2] 1-cycle pulse:
//     -> evt_valid=1, evt_ch=2 exactly one cycle, 2 cycles after pulse.
//   3 ready=1, edge_in=4'b1011 in one cycle, ptr=0:
//     -> evt_ch=0,1,3 on consecutive cycles.
//     -> then edge_in=4'hF gives 0,1,2,3.
//   4 ready=0, three pulses on ch1:
//     -> evt_ch=1 held valid, pending[1]=1, ovf=4'b0010.
//     -> ready=1 then yields two events on ch1.
//   5 init_n=0 one cycle while evt_valid=1, pending=4'b0110, ovf=4'b0001:
//     -> next cycle evt_valid=0, pending=0, ovf=0, det_init_n=0.
//     -> ARM, then RUN again.
//   6 ch_en=4'b1110, edge_in[0] pulses:
//     -> no event and no ovf.
//     -> a pending ch0 set before ch_en dropped is still delivered.

Source files
------------

// File: rtl/edge_event_arbiter_if.sv
// Event handshake between the arbiter and its downstream consumer.
// The arbiter side uses the master modport and the consumer side uses slave.
interface edge_event_arbiter_if #(
   parameter int CH_W = 2
);
   logic            evt_valid;
   logic [CH_W-1:0] evt_ch;
   logic            evt_ready;

   modport master (output evt_valid, output evt_ch, input evt_ready);
   modport slave  (input evt_valid, input evt_ch, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Sequences clear/re-arm of a bank of edge detectors, latches their pulses as
// pending events and hands them out round-robin over a valid/ready port.
module edge_event_arbiter #(
   parameter int NUM_CH  = 4,
   parameter int CH_W    = 2,
   parameter int ARM_DLY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_n,
   input  logic [NUM_CH-1:0]     ch_en,
   input  logic [NUM_CH-1:0]     edge_in,
   output logic                  det_init_n,
   edge_event_arbiter_if.master  evt,
   output logic [NUM_CH-1:0]     ovf,
   output logic                  busy
);

   typedef enum logic [1:0] {ST_CLR, ST_ARM, ST_RUN} state_t;

   state_t              state_reg, state_next;
   logic [3:0]          arm_cnt_reg, arm_cnt_next;
   logic [NUM_CH-1:0]   pending_reg, pending_next;
   logic [NUM_CH-1:0]   ovf_reg, ovf_next;
   logic [CH_W-1:0]     ptr_reg, ptr_next;
   logic                evt_valid_reg, evt_valid_next;
   logic [CH_W-1:0]     evt_ch_reg, evt_ch_next;
   logic                det_init_n_reg, busy_reg, busy_next;

   logic                load, found, take;
   logic [CH_W-1:0]     sel_idx, cand;
   logic [NUM_CH-1:0]   load_mask, cap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_CLR;
         arm_cnt_reg    <= '0;
         pending_reg    <= '0;
         ovf_reg        <= '0;
         ptr_reg        <= '0;
         evt_valid_reg  <= 1'b0;
         evt_ch_reg     <= '0;
         det_init_n_reg <= 1'b0;
         busy_reg       <= 1'b1;
      end else begin
         state_reg      <= state_next;
         arm_cnt_reg    <= arm_cnt_next;
         pending_reg    <= pending_next;
         ovf_reg        <= ovf_next;
         ptr_reg        <= ptr_next;
         evt_valid_reg  <= evt_valid_next;
         evt_ch_reg     <= evt_ch_next;
         det_init_n_reg <= (state_next != ST_CLR);
         busy_reg       <= busy_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      arm_cnt_next = arm_cnt_reg;
      if (!init_n) begin
         state_next   = ST_CLR;
         arm_cnt_next = '0;
      end else begin
         case (state_reg)
            ST_CLR: begin
               state_next   = ST_ARM;
               arm_cnt_next = '0;
            end
            ST_ARM: begin
               if (arm_cnt_reg == 4'(ARM_DLY - 1)) begin
                  state_next   = ST_RUN;
                  arm_cnt_next = '0;
               end else begin
                  arm_cnt_next = arm_cnt_reg + 4'd1;
               end
            end
            default: state_next = ST_RUN;
         endcase
      end
   end

   // Round-robin scan starting at ptr; first pending channel wins.
   always_comb begin
      found   = 1'b0;
      sel_idx = ptr_reg;
      cand    = ptr_reg;
      for (int off = 0; off < NUM_CH; off++) begin
         cand = CH_W'((int'(ptr_reg) + off) % NUM_CH);
         if (!found && pending_reg[cand]) begin
            found   = 1'b1;
            sel_idx = cand;
         end
      end
   end

   assign load = !evt_valid_reg || evt.evt_ready;
   assign take = init_n && load && found;

   always_comb begin
      load_mask = '0;
      if (take) load_mask[sel_idx] = 1'b1;
   end

   // A capture onto a pending bit that is leaving this cycle is not a loss.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign cap[gi]          = (state_reg == ST_RUN) && edge_in[gi] && ch_en[gi];
         assign pending_next[gi] = init_n && ((pending_reg[gi] && !load_mask[gi]) || cap[gi]);
         assign ovf_next[gi]     = init_n && (ovf_reg[gi] ||
                                   (cap[gi] && pending_reg[gi] && !load_mask[gi]));
      end
   endgenerate

   always_comb begin
      evt_valid_next = evt_valid_reg;
      evt_ch_next    = evt_ch_reg;
      ptr_next       = ptr_reg;
      if (!init_n) begin
         evt_valid_next = 1'b0;
      end else if (load) begin
         evt_valid_next = found;
      end
      if (take) begin
         evt_ch_next = sel_idx;
         ptr_next    = (sel_idx == CH_W'(NUM_CH - 1)) ? '0 : sel_idx + 1'b1;
      end
      busy_next = (state_next != ST_RUN) || (|pending_next) || evt_valid_next;
   end

   assign det_init_n    = det_init_n_reg;
   assign evt.evt_valid = evt_valid_reg;
   assign evt.evt_ch    = evt_ch_reg;
   assign ovf           = ovf_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: one task per scenario, inline checks.
module tb_edge_event_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       init_n;
   logic [3:0] ch_en;
   logic [3:0] edge_in;
   logic       det_init_n;
   logic [3:0] ovf;
   logic       busy;
   int         total;
   int         bad;

   edge_event_arbiter_if #(.CH_W(2)) evt_if ();

   edge_event_arbiter #(.NUM_CH(4), .CH_W(2), .ARM_DLY(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .init_n     (init_n),
      .ch_en      (ch_en),
      .edge_in    (edge_in),
      .det_init_n (det_init_n),
      .evt        (evt_if.master),
      .ovf        (ovf),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init();
      init_n = 1'b0;
      step();
      init_n = 1'b1;
      step(); step(); step();
   endtask

   task automatic test_reset();
      #2;
      total++; if (det_init_n !== 1'b0) begin bad++; $display("FAIL rst_det got=%b want=0", det_init_n); end
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", evt_if.evt_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", busy); end
      total++; if (ovf !== 4'h0) begin bad++; $display("FAIL rst_ovf got=%h want=0", ovf); end
      total++; if (evt_if.evt_ch !== 2'd0) begin bad++; $display("FAIL rst_ch got=%0d want=0", evt_if.evt_ch); end
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (det_init_n !== 1'b0) begin bad++; $display("FAIL clr_det got=%b want=0", det_init_n); end
      step();
      total++; if (det_init_n !== 1'b1) begin bad++; $display("FAIL arm_det got=%b want=1", det_init_n); end
      step(); step();
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL arm_nocap got=%b want=0", evt_if.evt_valid); end
      step();
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL run_first got=%b want=0", evt_if.evt_valid); end
      step();
      total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd0) begin bad++; $display("FAIL run_ch0 got=%b/%0d want=1/0", evt_if.evt_valid, evt_if.evt_ch); end
      total++; if (ovf !== 4'b1110) begin bad++; $display("FAIL held_ovf got=%b want=1110", ovf); end
      edge_in = 4'h0;
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'((i + 1) % 4)) begin
            bad++; $display("FAIL drain_%0d got=%b/%0d want=1/%0d", i, evt_if.evt_valid, evt_if.evt_ch, (i + 1) % 4);
         end
      end
      step();
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL drain_end got=%b want=0", evt_if.evt_valid); end
      do_init();
   endtask

   task automatic test_single();
      edge_in = 4'b0100;
      step();
      edge_in = 4'h0;
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL single_lat got=%b want=0", evt_if.evt_valid); end
      step();
      total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd2) begin bad++; $display("FAIL single_evt got=%b/%0d want=1/2", evt_if.evt_valid, evt_if.evt_ch); end
      step();
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL single_once got=%b want=0", evt_if.evt_valid); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp3 [3];
      exp3[0] = 2'd0; exp3[1] = 2'd1; exp3[2] = 2'd3;
      edge_in = 4'b1000;
      step();
      edge_in = 4'h0;
      step();
      total++; if (evt_if.evt_ch !== 2'd3) begin bad++; $display("FAIL rr_ptr_ch3 got=%0d want=3", evt_if.evt_ch); end
      edge_in = 4'b1011;
      step();
      edge_in = 4'h0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== exp3[i]) begin
            bad++; $display("FAIL rr_b1011_%0d got=%b/%0d want=1/%0d", i, evt_if.evt_valid, evt_if.evt_ch, exp3[i]);
         end
      end
      edge_in = 4'hF;
      step();
      edge_in = 4'h0;
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL rr_gap got=%b want=0", evt_if.evt_valid); end
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'(i)) begin
            bad++; $display("FAIL rr_all_%0d got=%b/%0d want=1/%0d", i, evt_if.evt_valid, evt_if.evt_ch, i);
         end
      end
      step();
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL rr_end got=%b want=0", evt_if.evt_valid); end
      total++; if (ovf !== 4'h0) begin bad++; $display("FAIL rr_ovf got=%b want=0000", ovf); end
   endtask

   task automatic test_overflow();
      evt_if.evt_ready = 1'b0;
      edge_in = 4'b0010;
      step(); step(); step();
      edge_in = 4'h0;
      total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd1) begin bad++; $display("FAIL ovf_evt got=%b/%0d want=1/1", evt_if.evt_valid, evt_if.evt_ch); end
      total++; if (ovf !== 4'b0010) begin bad++; $display("FAIL ovf_flag got=%b want=0010", ovf); end
      step(); step();
      total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd1) begin bad++; $display("FAIL ovf_hold got=%b/%0d want=1/1", evt_if.evt_valid, evt_if.evt_ch); end
      evt_if.evt_ready = 1'b1;
      step();
      total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd1) begin bad++; $display("FAIL ovf_second got=%b/%0d want=1/1", evt_if.evt_valid, evt_if.evt_ch); end
      step();
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", evt_if.evt_valid); end
      total++; if (ovf !== 4'b0010) begin bad++; $display("FAIL ovf_sticky got=%b want=0010", ovf); end
   endtask

   task automatic test_init();
      do_init();
      evt_if.evt_ready = 1'b0;
      edge_in = 4'b0001;
      step(); step(); step();
      edge_in = 4'b0110;
      step();
      edge_in = 4'h0;
      total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd0) begin bad++; $display("FAIL init_pre got=%b/%0d want=1/0", evt_if.evt_valid, evt_if.evt_ch); end
      total++; if (ovf !== 4'b0001) begin bad++; $display("FAIL init_pre_ovf got=%b want=0001", ovf); end
      init_n = 1'b0;
      step();
      init_n = 1'b1;
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL init_valid got=%b want=0", evt_if.evt_valid); end
      total++; if (ovf !== 4'h0) begin bad++; $display("FAIL init_ovf got=%b want=0000", ovf); end
      total++; if (det_init_n !== 1'b0) begin bad++; $display("FAIL init_det got=%b want=0", det_init_n); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL init_busy got=%b want=1", busy); end
      total++; if (evt_if.evt_ch !== 2'd0) begin bad++; $display("FAIL init_ch_kept got=%0d want=0", evt_if.evt_ch); end
      step();
      total++; if (det_init_n !== 1'b1) begin bad++; $display("FAIL init_rearm got=%b want=1", det_init_n); end
      step(); step();
      evt_if.evt_ready = 1'b1;
      step(); step();
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL init_pend_gone got=%b want=0", evt_if.evt_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_disabled();
      evt_if.evt_ready = 1'b0;
      edge_in = 4'b0001;
      step(); step();
      edge_in = 4'h0;
      total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd0) begin bad++; $display("FAIL dis_pre got=%b/%0d want=1/0", evt_if.evt_valid, evt_if.evt_ch); end
      ch_en = 4'b1110;
      edge_in = 4'b0001;
      step(); step();
      edge_in = 4'h0;
      total++; if (ovf !== 4'h0) begin bad++; $display("FAIL dis_ovf got=%b want=0000", ovf); end
      evt_if.evt_ready = 1'b1;
      step();
      total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd0) begin bad++; $display("FAIL dis_deliver got=%b/%0d want=1/0", evt_if.evt_valid, evt_if.evt_ch); end
      step();
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL dis_after got=%b want=0", evt_if.evt_valid); end
      edge_in = 4'b0001;
      step(); step();
      edge_in = 4'h0;
      step();
      total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL dis_block got=%b want=0", evt_if.evt_valid); end
      ch_en = 4'hF;
   endtask

   task automatic test_async_reset();
      edge_in = 4'b0100;
      step();
      edge_in = 4'h0;
      step();
      total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd2) begin bad++; $display("FAIL ar_pre got=%b/%0d want=1/2", evt_if.evt_valid, evt_if.evt_ch); end
      evt_if.evt_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_ch !== 2'd0) begin bad++; $display("FAIL ar_out got=%b/%0d want=0/0", evt_if.evt_valid, evt_if.evt_ch); end
      total++; if (det_init_n !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ar_ctl got=det%b/busy%b want=det0/busy1", det_init_n, busy); end
      step();
      rst = 1'b0;
      step();
      total++; if (det_init_n !== 1'b1) begin bad++; $display("FAIL ar_rearm got=%b want=1", det_init_n); end
   endtask

   initial begin
      total            = 0;
      bad              = 0;
      rst              = 1'b1;
      init_n           = 1'b1;
      ch_en            = 4'hF;
      edge_in          = 4'hF;
      evt_if.evt_ready = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_overflow();
      test_init();
      test_disabled();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
